// File: rtl/countdown_display_scan_pkg.sv
// Shared constants for the countdown display: segment codes and scan defaults.
package countdown_display_scan_pkg;

   // Segment patterns, {a,b,c,d,e,f,g,dp}, active-low
   localparam logic [7:0] SEG_OFF  = 8'hFF;
   localparam logic [7:0] SEG_DASH = 8'hFD;

   // Digit code that renders as a dash
   localparam logic [3:0] BCD_DASH = 4'd11;

   // Scan defaults
   localparam int N_DIG_DEF        = 4;
   localparam int REFRESH_DIV_DEF  = 100000;
   localparam int DEAD_DEF         = 16;
   localparam int BLINK_FRAMES_DEF = 64;

endpackage

// File: rtl/BCD_Encoder_c.sv
// Combinational BCD to seven-segment decoder, active-low, dp always off.
module BCD_Encoder_c
   import countdown_display_scan_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [7:0] seg_o
);

   // Code lookup; non-decimal codes other than the dash render blank
   always_comb begin
      seg_o = SEG_OFF;
      case (bcd_i)
         4'd0:     seg_o = 8'h03;
         4'd1:     seg_o = 8'h9F;
         4'd2:     seg_o = 8'h25;
         4'd3:     seg_o = 8'h0D;
         4'd4:     seg_o = 8'h99;
         4'd5:     seg_o = 8'h49;
         4'd6:     seg_o = 8'h41;
         4'd7:     seg_o = 8'h1F;
         4'd8:     seg_o = 8'h01;
         4'd9:     seg_o = 8'h09;
         BCD_DASH: seg_o = SEG_DASH;
         default:  seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/countdown_display_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Rotates one digit slot at a time through a shared decoder, with a
// frame-consistent digit shadow, leading-zero suppression, blanking,
// blinking, decimal points and anti-ghosting dead time.
module countdown_display_scan
   import countdown_display_scan_pkg::*;
#(
   parameter int N_DIG        = N_DIG_DEF,
   parameter int REFRESH_DIV  = REFRESH_DIV_DEF,
   parameter int DEAD         = DEAD_DEF,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [4*N_DIG-1:0] digits_in_i,
   input  logic               load_i,
   input  logic [N_DIG-1:0]   blank_mask_i,
   input  logic [N_DIG-1:0]   blink_en_i,
   input  logic               lz_suppress_i,
   input  logic [N_DIG-1:0]   dp_pos_i,
   output logic [N_DIG-1:0]   an_o,
   output logic [7:0]         seg_o,
   output logic               frame_done_o
);

   localparam int PW = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
   localparam int IW = (N_DIG > 1)        ? $clog2(N_DIG)        : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRESC_PRE  = PW'(REFRESH_DIV - 2);
   localparam logic [PW-1:0] DEAD_LEN   = PW'(DEAD);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]            presc_q, presc_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [BW-1:0]            blink_cnt_q, blink_cnt_d;
   logic                     blink_ph_q, blink_ph_d;
   logic [N_DIG-1:0][3:0]    active_q, active_d;
   logic [N_DIG-1:0][3:0]    pending_q, pending_d;
   logic [N_DIG-1:0][3:0]    din;
   logic [N_DIG-1:0]         an_q, an_d;
   logic [7:0]               seg_q, seg_d;
   logic                     frame_done_q, frame_done_d;

   logic                     slot_end, frame_end;
   logic [N_DIG-1:0]         zero_run;
   logic [3:0]               cur_digit;
   logic [7:0]               dec_seg;
   logic                     blanked, suppressed, digit_off, dp_on, in_dead;

   assign din       = digits_in_i;
   assign slot_end  = (presc_q == PRESC_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   // Next-state for the prescaler, slot index, blink timer and digit shadow
   always_comb begin
      presc_d     = slot_end ? '0 : presc_q + PW'(1);
      idx_d       = idx_q;
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      pending_d   = load_i ? din : pending_q;
      active_d    = active_q;
      if (slot_end)
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      if (frame_end) begin
         // A load landing on the boundary bypasses pending so it is not
         // delayed by a whole frame.
         active_d = load_i ? din : pending_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // Scan sequencing and digit shadow registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q     <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         active_q    <= '0;
         pending_q   <= '0;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
      end
   end

   // zero_run[i]: active digits N_DIG-1 down to i are all zero
   always_comb begin
      zero_run = '0;
      zero_run[N_DIG-1] = (active_q[N_DIG-1] == 4'd0);
      for (int i = N_DIG - 2; i >= 0; i--)
         zero_run[i] = zero_run[i+1] & (active_q[i] == 4'd0);
   end

   assign cur_digit = active_q[idx_q];

   BCD_Encoder_c u_dec (
      .bcd_i (cur_digit),
      .seg_o (dec_seg)
   );

   assign blanked    = blank_mask_i[idx_q] | (blink_en_i[idx_q] & blink_ph_q);
   assign suppressed = lz_suppress_i && (idx_q != '0) && zero_run[idx_q];
   assign digit_off  = blanked | suppressed;
   assign dp_on      = dp_pos_i[idx_q] & ~blanked;
   assign in_dead    = (presc_q < DEAD_LEN);

   // Pin drive for the current slot. A suppressed digit keeps its anode
   // on when it must still show its decimal point.
   always_comb begin
      an_d         = '1;
      seg_d        = SEG_OFF;
      frame_done_d = (idx_q == IDX_LAST) && (presc_q == PRESC_PRE);
      if (!in_dead) begin
         if (!digit_off)
            seg_d = dec_seg;
         if (dp_on)
            seg_d[0] = 1'b0;
         if (!digit_off || dp_on)
            an_d[idx_q] = 1'b0;
      end
   end

   // Registered pin outputs; frame_done is timed to line up with the boundary
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         an_q         <= '1;
         seg_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an_o         = an_q;
   assign seg_o        = seg_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_countdown_display_scan.sv
// Bench for countdown_display_scan: behavioural model derived from the
// cycle count since reset, checked every cycle, plus literal pins.
module tb_countdown_display_scan;

   localparam int N  = 4;
   localparam int RD = 4;
   localparam int DD = 1;
   localparam int BF = 2;
   localparam int FR = N * RD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din = '0;
   logic        load = 1'b0;
   logic [3:0]  blank = '0;
   logic [3:0]  blink = '0;
   logic        lz = 1'b0;
   logic [3:0]  dp = '0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        fd;

   int compared = 0;
   int mismatched = 0;

   countdown_display_scan #(
      .N_DIG(N), .REFRESH_DIV(RD), .DEAD(DD), .BLINK_FRAMES(BF)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .digits_in_i(din), .load_i(load),
      .blank_mask_i(blank), .blink_en_i(blink), .lz_suppress_i(lz),
      .dp_pos_i(dp), .an_o(an), .seg_o(seg), .frame_done_o(fd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 8'h03;  4'd1: return 8'h9F;  4'd2: return 8'h25;
         4'd3: return 8'h0D;  4'd4: return 8'h99;  4'd5: return 8'h49;
         4'd6: return 8'h41;  4'd7: return 8'h1F;  4'd8: return 8'h01;
         4'd9: return 8'h09;  4'd11: return 8'hFD;
         default: return 8'hFF;
      endcase
   endfunction

   // Model: cycle k after reset sits in slot (k/RD)%N at offset k%RD of
   // frame k/FR; blink phase is (frame/BF) odd. Outputs lag state by one.
   int          k = 0;
   logic [15:0] act_m = '0;
   logic [15:0] pend_m = '0;
   logic [3:0]  exp_an = 4'hF;
   logic [7:0]  exp_seg = 8'hFF;
   logic        exp_fd = 1'b0;

   always @(posedge clk or negedge rst_n) begin : mdl
      int i, off, phase;
      logic blk, sup, sdp;
      logic [7:0] s;
      logic [3:0] a;
      if (!rst_n) begin
         k <= 0; act_m <= '0; pend_m <= '0;
         exp_an <= 4'hF; exp_seg <= 8'hFF; exp_fd <= 1'b0;
      end else begin
         i     = (k / RD) % N;
         off   = k % RD;
         phase = (k / FR / BF) % 2;
         blk   = blank[i] | (blink[i] & (phase == 1));
         sup   = lz && (i > 0) && ((act_m >> (4 * i)) == 16'd0);
         sdp   = dp[i] && !blk;
         s = 8'hFF;
         a = 4'hF;
         if (off >= DD) begin
            if (!(blk || sup)) s = seg_of(act_m[4*i +: 4]);
            if (sdp) s = s & 8'hFE;
            if (!(blk || sup) || sdp) a = ~(4'b0001 << i);
         end
         exp_an  <= a;
         exp_seg <= s;
         exp_fd  <= (((k + 1) % FR) == FR - 1);
         if (k % FR == FR - 1) act_m <= load ? din : pend_m;
         if (load) pend_m <= din;
         k <= k + 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      check("an", {12'd0, an}, {12'd0, exp_an});
      check("seg", {8'd0, seg}, {8'd0, exp_seg});
      check("frame_done", {15'd0, fd}, {15'd0, exp_fd});
   end

   task automatic wait_fd(input string name);
      int n = 0;
      @(negedge clk);
      while (fd !== 1'b1 && n < 3 * FR) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (fd !== 1'b1) begin
         mismatched++;
         $display("FAIL %s: frame_done got %b expected 1 within %0d cycles", name, fd, 3 * FR);
      end
   endtask

   task automatic load_digits(input logic [15:0] v);
      din  = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_dead_an", {12'd0, an}, 16'h000F);
      check("rst_dead_seg", {8'd0, seg}, 16'h00FF);
      @(negedge clk);
      check("first_an", {12'd0, an}, 16'h000E);
      check("first_seg", {8'd0, seg}, 16'h0003);

      wait_fd("fd_first");
      repeat (FR - 1) @(negedge clk);
      check("fd_gap", {15'd0, fd}, 16'd0);
      @(negedge clk);
      check("fd_period", {15'd0, fd}, 16'd1);

      // Mid-frame load must not disturb the frame in progress
      repeat (6) @(negedge clk);
      load_digits(16'h1234);
      check("hold_old_seg", {8'd0, seg}, 16'h0003);
      wait_fd("fd_1234");
      repeat (3) @(negedge clk);
      check("new_d0_an", {12'd0, an}, 16'h000E);
      check("new_d0_seg", {8'd0, seg}, 16'h0099);
      repeat (12) @(negedge clk);
      check("new_d3_an", {12'd0, an}, 16'h0007);
      check("new_d3_seg", {8'd0, seg}, 16'h009F);

      // Leading-zero suppression
      lz = 1'b1;
      load_digits(16'h0050);
      repeat (3 * FR) @(negedge clk);
      load_digits(16'h0000);
      wait_fd("fd_zero");
      repeat (FR) @(negedge clk);
      repeat (3) @(negedge clk);
      check("lz_d0_seg", {8'd0, seg}, 16'h0003);
      repeat (4) @(negedge clk);
      check("lz_d1_an", {12'd0, an}, 16'h000F);
      lz = 1'b0;

      // Dash, blank code and decimal point
      dp = 4'b0010;
      load_digits(16'hB0A5);
      repeat (3 * FR) @(negedge clk);

      // Blink with dp on the blinking digit
      blink = 4'b0001;
      dp    = 4'b0001;
      load_digits(16'h0123);
      repeat (6 * FR) @(negedge clk);
      blink = '0;
      dp    = '0;

      // Load coincident with the frame boundary, then reset mid-slot
      wait_fd("fd_coinc");
      load_digits(16'h9876);
      repeat (2) @(negedge clk);
      check("coinc_an", {12'd0, an}, 16'h000E);
      check("coinc_seg", {8'd0, seg}, 16'h0041);
      #2 rst_n = 1'b0;
      #1;
      check("async_an", {12'd0, an}, 16'h000F);
      check("async_seg", {8'd0, seg}, 16'h00FF);
      check("async_fd", {15'd0, fd}, 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         if (c % 32 == 0) begin
            blank = 4'($urandom) & 4'($urandom);
            blink = 4'($urandom);
            dp    = 4'($urandom);
            lz    = 1'($urandom);
         end
         load = ($urandom_range(0, 5) == 0);
         din  = 16'($urandom) & ((c % 3 == 0) ? 16'h00FF : 16'hFFFF);
         @(negedge clk);
      end
      load = 1'b0;
      repeat (2 * FR) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
